// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : alu_multicycle
//  Purpose  : Sequential MIPS ALU with valid/ready handshakes, single-cycle
//             logic/arith/shift ops and iterative unsigned multiply/divide.
//  Revision : 1.0  initial release
// ============================================================================
module alu_multicycle #(
    parameter int WIDTH     = 32,
    parameter int MULDIV_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [SHW-1:0] C_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state, w_state_next;

    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_acc, r_q, r_b;
    logic             r_is_div;

    logic             w_accept, w_is_mul, w_is_div, w_multi, w_last;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_sum, w_dif, w_res;
    logic             w_ovf;
    logic [WIDTH:0]   w_mul_sum, w_dshift;
    logic [WIDTH-1:0] w_nacc, w_nq;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid & in_ready;
    assign w_is_mul  = (MULDIV_EN != 0) && (alu_control == 4'b1100);
    assign w_is_div  = (MULDIV_EN != 0) && (alu_control == 4'b1110);
    assign w_multi   = w_is_mul | w_is_div;
    assign w_last    = (r_cnt == C_LAST);
    assign w_shamt   = b[SHW-1:0];

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_sum = a + b;
        w_dif = a - b;
        case (alu_control)
            4'b0000: w_res = a & b;
            4'b0001: w_res = a | b;
            4'b0010: begin
                w_res = w_sum;
                w_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            4'b0011: w_res = a ^ b;
            4'b0100: w_res = ~(a | b);
            4'b0101: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            4'b0110: begin
                w_res = w_dif;
                w_ovf = (a[MSB] != b[MSB]) && (w_dif[MSB] != a[MSB]);
            end
            4'b0111: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1000: w_res = a << w_shamt;
            4'b1001: w_res = a >> w_shamt;
            4'b1010: w_res = $signed(a) >>> w_shamt;
            default: w_res = '0;
        endcase
    end

    // One iteration step: r_q holds the multiplier (shifted out LSB first)
    // or the dividend/quotient (dividend bits out MSB first, quotient bits in).
    always_comb begin
        w_mul_sum = {1'b0, r_acc} + {1'b0, r_b};
        w_dshift  = {r_acc, r_q[MSB]};
        w_nacc    = r_acc;
        w_nq      = r_q;
        if (r_is_div) begin
            // b == 0 always "fits", yielding an all-ones quotient and rem = a
            if (w_dshift >= {1'b0, r_b}) begin
                w_nacc = WIDTH'(w_dshift - {1'b0, r_b});
                w_nq   = {r_q[MSB-1:0], 1'b1};
            end else begin
                w_nacc = w_dshift[WIDTH-1:0];
                w_nq   = {r_q[MSB-1:0], 1'b0};
            end
        end else if (r_q[0]) begin
            {w_nacc, w_nq} = {w_mul_sum, r_q[MSB:1]};
        end else begin
            {w_nacc, w_nq} = {1'b0, r_acc, r_q[MSB:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = w_multi ? S_BUSY : S_DONE;
            S_BUSY:  if (w_last) w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_q         <= '0;
            r_b         <= '0;
            r_is_div    <= 1'b0;
            result      <= '0;
            hi          <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    if (w_multi) begin
                        r_acc    <= '0;
                        r_q      <= a;
                        r_b      <= b;
                        r_is_div <= w_is_div;
                        r_cnt    <= '0;
                    end else begin
                        result      <= w_res;
                        hi          <= '0;
                        zero        <= (w_res == '0);
                        overflow    <= w_ovf;
                        div_by_zero <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_nacc;
                    r_q   <= w_nq;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        result      <= w_nq;
                        hi          <= w_nacc;
                        zero        <= (w_nq == '0);
                        overflow    <= 1'b0;
                        div_by_zero <= r_is_div && (r_b == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
